cswap_fa_unit: RTL and testbench

CSWAP_FA_UNIT -- requirements
Module: cswap_fa

---
 rtl/cswap_fa_unit.sv | 140 ++++++++++++++
 tb/tb_cswap_fa_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cswap_fa_unit.sv
// rtl/cswap_fa_unit.sv - registered ripple adder built from Fredkin (controlled-swap) cells; optional macro CSWAP_FA_GARBAGE_EN exports garbage lines on G

// Fredkin primitive: the control passes through, and the two data lines swap when the control is 1.
module cswap_fa_fredkin (
    input  logic p,
    input  logic x,
    input  logic y,
    output logic o0,
    output logic o1,
    output logic o2
);
    // Controlled swap: the data lines pass straight through when p=0 and cross when p=1.
    always_comb begin
        o0 = p;
        o1 = p ? y : x;
        o2 = p ? x : y;
    end
endmodule

// One full-adder bit cell made from five Fredkin gates and constant ancillas.
module cswap_fa_cell (
    input  logic       a,
    input  logic       b,
    input  logic       ci,
    output logic       s,
    output logic       co,
    output logic [1:0] g
);
    logic b_n, b_c, a_c, t, c_c0, c_n, c_c1, t_c;
    logic unused_b0, unused_t_n, unused_s_n;

    // b with ancillas (1,0) yields ~b and a copy of b.
    cswap_fa_fredkin u_inv_b (
        .p(b), .x(1'b1), .y(1'b0),
        .o0(unused_b0), .o1(b_n), .o2(b_c)
    );

    // t = a ? ~b : b, which is a^b (the propagate term).
    cswap_fa_fredkin u_xor_ab (
        .p(a), .x(b_c), .y(b_n),
        .o0(a_c), .o1(t), .o2(unused_t_n)
    );

    // ci with ancillas (1,0) yields ~ci and two copies of ci.
    cswap_fa_fredkin u_inv_c (
        .p(ci), .x(1'b1), .y(1'b0),
        .o0(c_c0), .o1(c_n), .o2(c_c1)
    );

    // s = t ? ~ci : ci, which is t^ci.
    cswap_fa_fredkin u_sum (
        .p(t), .x(c_c0), .y(c_n),
        .o0(t_c), .o1(s), .o2(unused_s_n)
    );

    // co = t ? ci : a: when a and b differ the carry follows ci, otherwise it equals a (= b).
    cswap_fa_fredkin u_carry (
        .p(t_c), .x(a_c), .y(c_c1),
        .o0(g[0]), .o1(co), .o2(g[1])
    );
endmodule

module cswap_fa_unit #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic [WIDTH-1:0]   A1,
    output logic               B1,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               C
`ifdef CSWAP_FA_GARBAGE_EN
    ,
    output logic [2*WIDTH-1:0] G
`endif
);
    logic [WIDTH:0]     carry;
    logic [WIDTH-1:0]   sum_w;
    logic [2*WIDTH-1:0] garbage_unused;

    logic [WIDTH-1:0]   a1_d, a1_q;
    logic               b1_d, b1_q;

    assign carry[0] = C;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            cswap_fa_cell u_cell (
                .a (A[i]),
                .b (B[i]),
                .ci(carry[i]),
                .s (sum_w[i]),
                .co(carry[i+1]),
                .g (garbage_unused[2*i+1:2*i])
            );
        end
    endgenerate

    // Next-state for the output registers is the ripple result of the current operands.
    always_comb begin
        a1_d = sum_w;
        b1_d = carry[WIDTH];
    end

    // Output registers: reset wins over capture, so operands seen during reset are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q <= '0;
            b1_q <= 1'b0;
        end else begin
            a1_q <= a1_d;
            b1_q <= b1_d;
        end
    end

    assign A1 = a1_q;
    assign B1 = b1_q;

`ifdef CSWAP_FA_GARBAGE_EN
    logic [2*WIDTH-1:0] g_d, g_q;

    // Garbage lines are registered alongside the result so G aligns with A1/B1.
    always_comb begin
        g_d = garbage_unused;
    end

    // Garbage register with the same reset behaviour as the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q <= '0;
        end else begin
            g_q <= g_d;
        end
    end

    assign G = g_q;
`endif
endmodule

// File: tb/tb_cswap_fa_unit.sv
// tb/tb_cswap_fa_unit.sv - directed and random checks of cswap_fa_unit at WIDTH 1, 4 and 8
`timescale 1ns/1ps
module tb_cswap_fa_unit;
    logic clk;
    logic rst;

    logic       a1_i, b1_i, c1_i;
    logic       s1_o, co1_o;
    logic [3:0] a4_i, b4_i;
    logic       c4_i;
    logic [3:0] s4_o;
    logic       co4_o;
    logic [7:0] a8_i, b8_i;
    logic       c8_i;
    logic [7:0] s8_o;
    logic       co8_o;
`ifdef CSWAP_FA_GARBAGE_EN
    logic [1:0]  g1_o;
    logic [7:0]  g4_o;
    logic [15:0] g8_o;
`endif

    int n_cmp;
    int n_err;

    cswap_fa_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .A1(s1_o), .B1(co1_o),
        .A(a1_i), .B(b1_i), .C(c1_i)
`ifdef CSWAP_FA_GARBAGE_EN
        , .G(g1_o)
`endif
    );

    cswap_fa_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .A1(s4_o), .B1(co4_o),
        .A(a4_i), .B(b4_i), .C(c4_i)
`ifdef CSWAP_FA_GARBAGE_EN
        , .G(g4_o)
`endif
    );

    cswap_fa_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .A1(s8_o), .B1(co8_o),
        .A(a8_i), .B(b8_i), .C(c8_i)
`ifdef CSWAP_FA_GARBAGE_EN
        , .G(g8_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // WIDTH=1 truth table {B1,A1} for ABC = 000..111
    logic [1:0] tt1 [8];
    // WIDTH=4 vectors: a, b, c, expected {B1,A1}
    logic [3:0] va [6];
    logic [3:0] vb [6];
    logic       vc [6];
    logic [4:0] ve [6];

    initial begin
        logic [8:0] exp8;
        n_cmp = 0;
        n_err = 0;
        tt1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        va  = '{4'hF, 4'h5, 4'hF, 4'h0, 4'h9, 4'h3};
        vb  = '{4'h0, 4'hA, 4'hF, 4'h0, 4'h8, 4'h6};
        vc  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ve  = '{5'h10, 5'h0F, 5'h1F, 5'h00, 5'h11, 5'h0A};

        // Reset with all operands at ones: outputs must still clear.
        rst  = 1'b1;
        a1_i = 1'b1;  b1_i = 1'b1;  c1_i = 1'b1;
        a4_i = 4'hF;  b4_i = 4'hF;  c4_i = 1'b1;
        a8_i = 8'hFF; b8_i = 8'hFF; c8_i = 1'b1;
        tick();
        check("rst_w1", {co1_o, s1_o}, 32'h0);
        check("rst_w4", {co4_o, s4_o}, 32'h0);
        check("rst_w8", {co8_o, s8_o}, 32'h0);
`ifdef CSWAP_FA_GARBAGE_EN
        check("rst_g1", g1_o, 32'h0);
        check("rst_g4", g4_o, 32'h0);
        check("rst_g8", g8_o, 32'h0);
`endif

        // First edge after reset captures the held all-ones operands.
        rst = 1'b0;
        tick();
        check("post_rst_w1", {co1_o, s1_o}, 32'h3);
        check("post_rst_w4", {co4_o, s4_o}, 32'h1F);
        check("post_rst_w8", {co8_o, s8_o}, 32'h1FF);

        // WIDTH=1 exhaustive sweep, one combination per cycle.
        for (int i = 0; i < 8; i++) begin
            {a1_i, b1_i, c1_i} = 3'(i);
            tick();
            check($sformatf("sweep_w1_%0d", i), {co1_o, s1_o}, {30'h0, tt1[i]});
        end

        // WIDTH=4 directed vectors.
        for (int i = 0; i < 6; i++) begin
            a4_i = va[i]; b4_i = vb[i]; c4_i = vc[i];
            tick();
            check($sformatf("vec_w4_%0d", i), {co4_o, s4_o}, {27'h0, ve[i]});
        end

        // Mid-cycle input change must not reach the outputs before the next edge.
        a4_i = 4'h1; b4_i = 4'h1; c4_i = 1'b0;
        tick();
        check("lat_base_w4", {co4_o, s4_o}, 32'h02);
        #3;
        a4_i = 4'h7; b4_i = 4'h7; c4_i = 1'b1;
        #2;
        check("lat_hold_w4", {co4_o, s4_o}, 32'h02);
        tick();
        check("lat_next_w4", {co4_o, s4_o}, 32'h0F);

        // Mid-stream reset discards the operands of that cycle, then capture resumes.
        a4_i = 4'h3; b4_i = 4'h4; c4_i = 1'b0;
        a1_i = 1'b1; b1_i = 1'b1; c1_i = 1'b1;
        rst = 1'b1;
        tick();
        check("mid_rst_w4", {co4_o, s4_o}, 32'h0);
        check("mid_rst_w1", {co1_o, s1_o}, 32'h0);
        rst = 1'b0;
        tick();
        check("resume_w4", {co4_o, s4_o}, 32'h07);
        check("resume_w1", {co1_o, s1_o}, 32'h3);

        // WIDTH=8 random run against a one-cycle-delayed reference sum.
        for (int i = 0; i < 1000; i++) begin
            a8_i = 8'($urandom);
            b8_i = 8'($urandom);
            c8_i = 1'($urandom);
            exp8 = {1'b0, a8_i} + {1'b0, b8_i} + {8'h0, c8_i};
            tick();
            check($sformatf("rand_w8_%0d", i), {co8_o, s8_o}, {23'h0, exp8});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
